// File: rtl/chunk_serial_adder_if.sv
// Operand/result bundle for chunk_serial_adder: the requester drives start/sub/cin/A/B,
// the adder returns S/cout/ovf with a busy/done handshake.
interface chunk_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (output start, sub, cin, A, B, input S, cout, ovf, busy, done);
    modport slave  (input start, sub, cin, A, B, output S, cout, ovf, busy, done);
endinterface

// File: rtl/chunk_serial_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock through one ripple slice, WIDTH/CHUNK cycles.
// Optional macro SAT_ADDER_SATURATE_EN clamps S to signed min/max on overflow.
module chunk_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    chunk_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic             accept, last;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;

    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q, done_q;

    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] raw_sum, s_final;
    logic             ovf_raw;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                accept = bus.start;
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                last = (k_q == KW'(N - 1));
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slice k of the latched operands; sum_q is zero above the slices already done,
    // so the new slice can simply be OR-ed into place.
    always_comb begin
        a_sl    = CHUNK'(a_q >> (k_q * CHUNK));
        b_sl    = CHUNK'(b_q >> (k_q * CHUNK));
        slice   = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(carry_q);
        raw_sum = sum_q | (WIDTH'(slice[CHUNK-1:0]) << (k_q * CHUNK));
        ovf_raw = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw_sum[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SAT_ADDER_SATURATE_EN
        if (ovf_raw) s_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
        else         s_final = raw_sum;
`else
        s_final = raw_sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q     <= bus.A;
                b_q     <= bus.B ^ {WIDTH{bus.sub}};
                carry_q <= bus.sub ? 1'b1 : bus.cin;
                sum_q   <= '0;
                k_q     <= '0;
            end else if (state_q == RUN) begin
                sum_q   <= raw_sum;
                carry_q <= slice[CHUNK];
                k_q     <= k_q + KW'(1);
                if (last) begin
                    s_q    <= s_final;
                    cout_q <= slice[CHUNK];
                    ovf_q  <= ovf_raw;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.S    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q == RUN);
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder: WIDTH=8/CHUNK=4 instance plus a CHUNK=1 instance.
module tb_chunk_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat;
    int   seen;

    always #5 clk = ~clk;

    chunk_serial_adder_if #(.WIDTH(8)) bus0 ();
    chunk_serial_adder_if #(.WIDTH(8)) bus1 ();

    chunk_serial_adder #(.WIDTH(8), .CHUNK(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    chunk_serial_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op on bus0 at the current negedge, return cycles until done (bounded).
    task automatic op0(input logic s, input logic c, input logic [7:0] a, input logic [7:0] b,
                       output int l);
        bus0.start = 1'b1; bus0.sub = s; bus0.cin = c; bus0.A = a; bus0.B = b;
        @(negedge clk);
        bus0.start = 1'b0;
        l = 1;
        while (!bus0.done && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run_check(input string tag, input logic s, input logic c,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] es, input logic ec, input logic eo);
        int l;
        op0(s, c, a, b, l);
        chk({tag, "_lat"},  l, 3);
        chk({tag, "_S"},    bus0.S, es);
        chk({tag, "_cout"}, bus0.cout, ec);
        chk({tag, "_ovf"},  bus0.ovf, eo);
    endtask

    initial begin
        bus0.start = 0; bus0.sub = 0; bus0.cin = 0; bus0.A = 0; bus0.B = 0;
        bus1.start = 0; bus1.sub = 0; bus1.cin = 0; bus1.A = 0; bus1.B = 0;
        repeat (3) @(negedge clk);
        chk("rst_S", bus0.S, 0);
        chk("rst_cout", bus0.cout, 0);
        chk("rst_ovf", bus0.ovf, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_done", bus0.done, 0);
        rst = 1'b0;
        @(negedge clk);

        // 0xFF + 0x01 with busy/done timing walked cycle by cycle
        bus0.start = 1; bus0.sub = 0; bus0.cin = 0; bus0.A = 8'hFF; bus0.B = 8'h01;
        @(negedge clk); bus0.start = 0;
        chk("t1_busy_c1", bus0.busy, 1);
        chk("t1_done_c1", bus0.done, 0);
        chk("t1_S_hold_c1", bus0.S, 0);
        @(negedge clk);
        chk("t1_busy_c2", bus0.busy, 1);
        chk("t1_done_c2", bus0.done, 0);
        @(negedge clk);
        chk("t1_done_c3", bus0.done, 1);
        chk("t1_busy_c3", bus0.busy, 0);
        chk("t1_S", bus0.S, 8'h00);
        chk("t1_cout", bus0.cout, 1);
        chk("t1_ovf", bus0.ovf, 0);
        @(negedge clk);
        chk("t1_done_pulse", bus0.done, 0);

`ifdef SAT_ADDER_SATURATE_EN
        run_check("t2_add_ovf", 0, 0, 8'h7F, 8'h01, 8'h7F, 0, 1);
        run_check("t3_sub_ovf", 1, 0, 8'h80, 8'h01, 8'h80, 1, 1);
        run_check("neg_ovf",    0, 0, 8'h80, 8'h80, 8'h80, 1, 1);
`else
        run_check("t2_add_ovf", 0, 0, 8'h7F, 8'h01, 8'h80, 0, 1);
        run_check("t3_sub_ovf", 1, 0, 8'h80, 8'h01, 8'h7F, 1, 1);
        run_check("neg_ovf",    0, 0, 8'h80, 8'h80, 8'h00, 1, 1);
`endif
        run_check("t3_sub",     1, 0, 8'h05, 8'h07, 8'hFE, 0, 0);
        run_check("add_cin",    0, 1, 8'h12, 8'h34, 8'h47, 0, 0);
        run_check("sub_cin_ig", 1, 1, 8'h10, 8'h01, 8'h0F, 1, 0);
        @(negedge clk);

        // start during busy ignored; start in done cycle accepted
        bus0.start = 1; bus0.sub = 0; bus0.cin = 0; bus0.A = 8'h01; bus0.B = 8'h02;
        @(negedge clk);
        bus0.A = 8'h10;
        @(negedge clk);
        bus0.start = 0;
        @(negedge clk);
        chk("t4_done_c3", bus0.done, 1);
        chk("t4_S_first", bus0.S, 8'h03);
        bus0.start = 1; bus0.A = 8'h20; bus0.B = 8'h01;
        @(negedge clk);
        bus0.start = 0;
        chk("t4_busy_c4", bus0.busy, 1);
        chk("t4_S_hold_c4", bus0.S, 8'h03);
        @(negedge clk);
        chk("t4_S_hold_c5", bus0.S, 8'h03);
        @(negedge clk);
        chk("t4_done_c6", bus0.done, 1);
        chk("t4_S_second", bus0.S, 8'h21);
        @(negedge clk);

        // reset in the middle of an op
        bus0.start = 1; bus0.A = 8'h11; bus0.B = 8'h22;
        @(negedge clk); bus0.start = 0;
        @(negedge clk); rst = 1;
        @(negedge clk);
        chk("t5_busy", bus0.busy, 0);
        chk("t5_S", bus0.S, 0);
        chk("t5_done", bus0.done, 0);
        rst = 0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus0.done) seen++;
        end
        chk("t5_no_done", seen, 0);
        run_check("t5_after", 0, 0, 8'h11, 8'h22, 8'h33, 0, 0);

        // CHUNK=1 instance: 0x55 + 0xAA + 1
        @(negedge clk);
        bus1.start = 1; bus1.sub = 0; bus1.cin = 1; bus1.A = 8'h55; bus1.B = 8'hAA;
        @(negedge clk);
        bus1.start = 0;
        lat = 1;
        while (!bus1.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_lat", lat, 9);
        chk("t6_S", bus1.S, 8'h00);
        chk("t6_cout", bus1.cout, 1);
        chk("t6_ovf", bus1.ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
